// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI register controller: FSM encoding, register
// map addresses and command-byte field positions.
package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    SKIP  = 2'd3
  } state_e;

  localparam logic [3:0] CTRL_LAST = 4'd7;
  localparam logic [3:0] STAT_BASE = 4'd8;
  localparam logic [3:0] ID_ADDR   = 4'd15;
  localparam int         RW_BIT    = 7;
  localparam logic [3:0] XFER_LEN  = 4'd8;

endpackage

// File: rtl/spi_byte_evt.sv
// Rising-edge detector on the SPI slave's byte-ready level, gated by chip select.
module spi_byte_evt (
  input  logic clk,
  input  logic rst,
  input  logic cs_n,
  input  logic rx_rdy,
  output logic byte_evt
);

  logic rx_rdy_q;

  // History resets high so a byte-ready level already present at reset is not an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_rdy_q <= 1'b1;
    else     rx_rdy_q <= rx_rdy;
  end

  assign byte_evt = rx_rdy & ~rx_rdy_q & ~cs_n;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command decoder: writes control registers 0..7 and presents read data
// (control, status, ID) for the next frame, with a sticky illegal-access flag.
module spi_reg_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter logic [7:0] ID_VAL = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic [3:0]  xfer_len,
  output logic [7:0]  tx_data,
  input  logic [31:0] status_in,
  output logic [63:0] ctrl_regs,
  output logic [7:0]  wr_strobe,
  output logic        cmd_err
);

  state_e     state_q, state_d;
  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] rd_ptr_q, rd_ptr_d;
  logic [7:0] ctrl_q [8];
  logic [7:0] ctrl_d [8];
  logic [7:0] strobe_q, strobe_d;
  logic       err_q, err_d;
  logic       noinc_q, noinc_d;
  logic       armed_q, armed_d;
  logic       byte_evt;

  spi_byte_evt u_byte_evt (
    .clk      (clk),
    .rst      (rst),
    .cs_n     (cs_n),
    .rx_rdy   (rx_rdy),
    .byte_evt (byte_evt)
  );

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ctrl_d   = ctrl_q;
    strobe_d = '0;
    err_d    = err_q;
    noinc_d  = noinc_q;
    // A frame cut by reset must not resume until chip select has been seen idle.
    armed_d  = armed_q | cs_n;

    if (cs_n) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
        noinc_d = 1'b0;
        if (!noinc_q) rd_ptr_d = rd_ptr_q + 4'd1;
      end
    end else begin
      unique case (state_q)
        IDLE: if (armed_q) state_d = CMD;
        CMD: if (byte_evt) begin
          if (rx_data[6:4] != 3'b000) begin
            err_d   = 1'b1;
            noinc_d = 1'b1;
            state_d = SKIP;
          end else if (rx_data[RW_BIT]) begin
            rd_ptr_d = rx_data[3:0];
            noinc_d  = 1'b1;
            state_d  = SKIP;
          end else begin
            wr_ptr_d = rx_data[3:0];
            state_d  = WDATA;
          end
        end
        WDATA: if (byte_evt) begin
          wr_ptr_d = wr_ptr_q + 4'd1;
          if (wr_ptr_q <= CTRL_LAST) begin
            ctrl_d[wr_ptr_q[2:0]]   = rx_data;
            strobe_d[wr_ptr_q[2:0]] = 1'b1;
            // Reg 7 bit 7 is a self-clearing error-clear command, never stored.
            if (wr_ptr_q == CTRL_LAST) begin
              ctrl_d[7][7] = 1'b0;
              if (rx_data[7]) err_d = 1'b0;
            end
          end else begin
            err_d   = 1'b1;
            noinc_d = 1'b1;
          end
        end
        SKIP: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the register file is reset
  // because its contents are visible on ctrl_regs straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < 8; i++) ctrl_q[i] <= '0;
      strobe_q <= '0;
      err_q    <= 1'b0;
      noinc_q  <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ctrl_q   <= ctrl_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
      noinc_q  <= noinc_d;
      armed_q  <= armed_d;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    if (rd_ptr_q <= CTRL_LAST)               tx_data = ctrl_q[rd_ptr_q[2:0]];
    else if (rd_ptr_q < STAT_BASE + 4'd4)    tx_data = status_in[{rd_ptr_q[1:0], 3'b000} +: 8];
    else if (rd_ptr_q == ID_ADDR)            tx_data = ID_VAL;
  end

  for (genvar g = 0; g < 8; g++) begin : g_ctrl
    assign ctrl_regs[8*g +: 8] = ctrl_q[g];
  end

  assign wr_strobe = strobe_q;
  assign cmd_err   = err_q;
  assign xfer_len  = XFER_LEN;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed scenarios plus random frames
// checked against a frame-level register-map model.
module tb_spi_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic [3:0]  xfer_len;
  logic [7:0]  tx_data;
  logic [31:0] status_in;
  logic [63:0] ctrl_regs;
  logic [7:0]  wr_strobe;
  logic        cmd_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_regs [8];
  logic [3:0] m_rd;
  logic [3:0] m_wr;
  logic       m_err;
  logic [7:0] exp_strb [$];

  spi_reg_ctrl #(.ID_VAL(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs_n      (cs_n),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .xfer_len  (xfer_len),
    .tx_data   (tx_data),
    .status_in (status_in),
    .ctrl_regs (ctrl_regs),
    .wr_strobe (wr_strobe),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] m_ctrl();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = m_regs[i];
    return v;
  endfunction

  function automatic logic [7:0] m_tx();
    logic [31:0] sh;
    if (m_rd < 4'd8) return m_regs[m_rd[2:0]];
    if (m_rd < 4'd12) begin
      sh = status_in >> (8 * (int'(m_rd) - 8));
      return sh[7:0];
    end
    if (m_rd == 4'd15) return 8'hA5;
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_rd  = 4'd0;
    m_wr  = 4'd0;
    m_err = 1'b0;
  endtask

  // Applies a whole frame to the register map and lists the strobe expected per byte.
  task automatic model_frame(input logic [7:0] b [$]);
    logic [7:0] cmd;
    logic [7:0] d;
    int         a;
    bit         no_inc;
    no_inc = 1'b0;
    exp_strb.delete();
    if (b.size() > 0) begin
      cmd = b[0];
      exp_strb.push_back(8'h00);
      if (cmd[6:4] != 3'b000) begin
        m_err  = 1'b1;
        no_inc = 1'b1;
        for (int i = 1; i < b.size(); i++) exp_strb.push_back(8'h00);
      end else if (cmd[7]) begin
        m_rd   = cmd[3:0];
        no_inc = 1'b1;
        for (int i = 1; i < b.size(); i++) exp_strb.push_back(8'h00);
      end else begin
        m_wr = cmd[3:0];
        for (int i = 1; i < b.size(); i++) begin
          a = int'(m_wr);
          d = b[i];
          if (a < 8) begin
            m_regs[a] = (a == 7) ? (d & 8'h7F) : d;
            exp_strb.push_back(8'(1 << a));
            if (a == 7 && d[7]) m_err = 1'b0;
          end else begin
            m_err  = 1'b1;
            no_inc = 1'b1;
            exp_strb.push_back(8'h00);
          end
          m_wr = 4'((a + 1) % 16);
        end
      end
    end
    if (!no_inc) m_rd = 4'((int'(m_rd) + 1) % 16);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] exp_s);
    rx_rdy = 1'b0;
    tick();
    tick();
    rx_data = b;
    rx_rdy  = 1'b1;
    tick();
    checks++;
    if (wr_strobe !== exp_s) begin
      errors++;
      $display("FAIL strobe byte=%h got %h exp %h", b, wr_strobe, exp_s);
    end
    tick();
    checks++;
    if (wr_strobe !== 8'h00) begin
      errors++;
      $display("FAIL strobe_clear byte=%h got %h exp 00", b, wr_strobe);
    end
  endtask

  task automatic run_frame(input logic [7:0] b [$]);
    model_frame(b);
    cs_n = 1'b0;
    tick();
    tick();
    for (int i = 0; i < b.size(); i++) send_byte(b[i], exp_strb[i]);
    cs_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic check_state(input string name);
    checks++;
    if (ctrl_regs !== m_ctrl()) begin
      errors++;
      $display("FAIL %s ctrl_regs got %h exp %h", name, ctrl_regs, m_ctrl());
    end
    checks++;
    if (cmd_err !== m_err) begin
      errors++;
      $display("FAIL %s cmd_err got %b exp %b", name, cmd_err, m_err);
    end
    checks++;
    if (tx_data !== m_tx()) begin
      errors++;
      $display("FAIL %s tx_data got %h exp %h", name, tx_data, m_tx());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cs_n = 1'b1; rx_rdy = 1'b1; rx_data = 8'h00; status_in = 32'h0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (ctrl_regs !== 64'h0 || wr_strobe !== 8'h00 || cmd_err !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got regs=%h strb=%h err=%b tx=%h exp all zero",
               ctrl_regs, wr_strobe, cmd_err, tx_data);
    end
    checks++;
    if (xfer_len !== 4'd8) begin
      errors++;
      $display("FAIL xfer_len got %0d exp 8", xfer_len);
    end
  endtask

  task automatic test_burst_write();
    run_frame('{8'h02, 8'h11, 8'h22});
    check_state("burst_write");
    checks++;
    if (ctrl_regs[23:16] !== 8'h11 || ctrl_regs[31:24] !== 8'h22) begin
      errors++;
      $display("FAIL burst_regs got reg2=%h reg3=%h exp 11 22", ctrl_regs[23:16], ctrl_regs[31:24]);
    end
  endtask

  task automatic test_read();
    run_frame('{8'h8F});
    check_state("read_id");
    checks++;
    if (tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL read_id_value got %h exp a5", tx_data);
    end
    status_in = 32'hDEADBEEF;
    run_frame('{8'h89});
    check_state("read_status");
    checks++;
    if (tx_data !== 8'hBE) begin
      errors++;
      $display("FAIL read_status_value got %h exp be", tx_data);
    end
  endtask

  task automatic test_wrap_err();
    run_frame('{8'h07, 8'h01, 8'h33});
    check_state("wrap_err");
    checks++;
    if (cmd_err !== 1'b1 || ctrl_regs[63:56] !== 8'h01) begin
      errors++;
      $display("FAIL wrap_err_direct got err=%b reg7=%h exp 1 01", cmd_err, ctrl_regs[63:56]);
    end
    run_frame('{8'h07, 8'h80});
    check_state("err_clear");
    checks++;
    if (cmd_err !== 1'b0 || ctrl_regs[63] !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_direct got err=%b reg7=%h exp 0 00", cmd_err, ctrl_regs[63:56]);
    end
  endtask

  task automatic test_reserved();
    run_frame('{8'h35, 8'h5A});
    check_state("reserved");
    checks++;
    if (cmd_err !== 1'b1) begin
      errors++;
      $display("FAIL reserved_err got %b exp 1", cmd_err);
    end
  endtask

  task automatic test_idle_glitch();
    cs_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx_rdy  = 1'b0;
      rx_data = 8'($urandom);
      tick();
      rx_rdy = 1'b1;
      tick();
      checks++;
      if (wr_strobe !== 8'h00) begin
        errors++;
        $display("FAIL idle_glitch_strobe got %h exp 00", wr_strobe);
      end
    end
    check_state("idle_glitch");
    run_frame('{8'h05, 8'h6C});
    check_state("after_glitch");
  endtask

  task automatic test_random();
    logic [7:0] fr [$];
    logic [7:0] cmd;
    int         n;
    for (int f = 0; f < 40; f++) begin
      fr.delete();
      status_in = $urandom;
      n = $urandom_range(0, 6);
      if (n > 0) begin
        cmd = 8'($urandom);
        if ($urandom_range(0, 3) != 0) cmd[6:4] = 3'b000;
        fr.push_back(cmd);
        for (int i = 1; i < n; i++) fr.push_back(8'($urandom));
      end
      run_frame(fr);
      check_state("random");
    end
  endtask

  task automatic test_abort();
    run_frame('{8'h04, 8'h3C});
    check_state("pre_abort");
    cs_n = 1'b0;
    tick();
    tick();
    send_byte(8'h01, 8'h00);
    rst = 1'b1;
    #2;
    model_reset();
    check_state("abort_reset");
    checks++;
    if (wr_strobe !== 8'h00) begin
      errors++;
      $display("FAIL abort_strobe got %h exp 00", wr_strobe);
    end
    tick();
    rst = 1'b0;
    tick();
    send_byte(8'h55, 8'h00);
    check_state("abort_data");
    cs_n = 1'b1;
    tick();
    tick();
    check_state("abort_end");
    run_frame('{8'h03, 8'h77});
    check_state("post_abort");
  endtask

  initial begin
    test_reset();
    test_burst_write();
    test_read();
    test_wrap_err();
    test_reserved();
    test_idle_glitch();
    test_random();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter ID_VAL, default 8'hA5, constant byte returned at address 15.
REQ-002 SHALL have port clk  in  1  single system clock; all logic in this domain.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port cs_n  in  1  frame-active-low chip select, already synchronized to clk.
REQ-005 SHALL have port rx_rdy  in  1  byte-ready level from SPI slave: 0 during a byte, 1 when a byte completes or the frame is idle.
REQ-006 SHALL have port rx_data  in  8  received byte, valid while rx_rdy=1.
REQ-007 SHALL have port xfer_len  out  4  transfer length to SPI slave, constant 4'd8.
REQ-008 SHALL have port tx_data  out  8  byte the SPI slave loads for the next frame.
REQ-009 SHALL have port status_in  in  32  read-only status; byte k maps to address 8+k.
REQ-010 SHALL have port ctrl_regs  out  64  control registers 0..7; reg n at bits [8n+7:8n].
REQ-011 SHALL have port wr_strobe  out  8  one-cycle pulse per control register written.
REQ-012 SHALL have port cmd_err  out  1  sticky flag set by illegal access; cleared by a write to reg 7 bit 7.

Function
REQ-013 SHALL detect a byte event as rx_rdy=1, previous-cycle rx_rdy=0 and cs_n=0; exactly one event per 0->1 edge.
REQ-014 SHALL implement FSM states IDLE, CMD, WDATA, SKIP.
REQ-015 SHALL go IDLE->CMD when cs_n=0, and go from any state to IDLE on the first cycle with cs_n=1, without acting on a byte event in that cycle.
REQ-016 SHALL decode the first byte event in CMD as bit7=R/W (1=read), bits6:4 reserved, bits3:0 addr.
REQ-017 SHALL, for a write command, load addr into wr_ptr and go to WDATA.
REQ-018 SHALL, for a read command, load addr into rd_ptr and go to SKIP.
REQ-019 SHALL, on each byte event in WDATA with wr_ptr<8, write rx_data into ctrl_regs[wr_ptr] and pulse wr_strobe[wr_ptr] on the same clock edge, so the value is visible one cycle after rx_rdy rises.
REQ-020 SHALL, on each byte event in WDATA with wr_ptr>=8, discard the byte and set cmd_err.
REQ-021 SHALL increment wr_ptr after every WDATA byte event, wrapping 15->0.
REQ-022 SHALL set cmd_err on a command byte with nonzero reserved bits, treat that frame as SKIP, and leave both pointers unchanged.
REQ-023 SHALL ignore all byte events in SKIP.
REQ-024 SHALL drive tx_data combinationally from rd_ptr: 0-7 ctrl_regs, 8-11 status_in bytes, 12-14 8'h00, 15 ID_VAL.
REQ-025 SHALL post-increment rd_ptr (wrap 15->0) on the cycle cs_n rises after a frame that was neither a read command nor an error; a read frame leaves rd_ptr at the commanded address.
REQ-026 SHALL give a write of bit7=1 to reg 7 priority over any cmd_err set in the same cycle, clearing cmd_err; reg 7 bit 7 always reads back 0.

Reset
REQ-027 SHALL reset asynchronously on rst=1:
- ctrl_regs=0, wr_strobe=0, cmd_err=0
- rd_ptr=0, wr_ptr=0, rx_rdy history=1
- FSM=IDLE; tx_data therefore 8'h00
REQ-028 SHALL abandon a frame on reset mid-frame and stay in IDLE until cs_n is seen high then low again.

Structure
REQ-029 SHALL place in shared package spi_ctrl_pkg: FSM state encoding, address constants (CTRL_LAST=7, STAT_BASE=8, ID_ADDR=15) and RW bit index.
REQ-030 SHALL be a single module with no sub-modules, except optionally spi_byte_evt (rx_rdy edge detector).

Verification
REQ-031 SHALL cover burst write: frame 0x02,0x11,0x22 -> ctrl_regs reg2=0x11, reg3=0x22; wr_strobe pulses 0x04 then 0x08.
REQ-032 SHALL cover read: frame 0x8F -> next frame tx_data=0xA5; status_in=0xDEADBEEF with read 0x89 -> tx_data=0xBE.
REQ-033 SHALL cover wrap and error: frame 0x07,0x01,0x33 -> reg7=0x01, address 8 write discarded, cmd_err=1; frame 0x07,0x80 -> cmd_err=0.
REQ-034 SHALL cover reserved bits: command 0x35 -> cmd_err=1, no wr_strobe, rd_ptr unchanged.
REQ-035 SHALL cover abort: rst asserted after command 0x01 and before the data byte -> all outputs zero; a following data byte writes nothing.
REQ-036 SHALL cover idle-cs glitch: rx_rdy toggles with cs_n=1 -> no writes and no FSM change.
